clock_ctrl: RTL and testbench

CLOCK_CTRL -- requirements
Module: clock_ctrl

---
 rtl/clock_pkg.sv | 24 ++
 rtl/clock_div_ch.sv | 114 +++++++++++
 rtl/clock_ctrl.sv | 88 ++++++++
 tb/tb_clock_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the clock controller:
//   mode_e          - run-control encoding carried on clock_ctrl.mode
//   CLK_DEFAULT_DIV - divisor loaded into every channel at reset
//   mode_is_halt    - true for HALT and for the reserved encoding
// ---------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        STEP = 2'b01,
        HALT = 2'b10,
        RSVD = 2'b11
    } mode_e;

    localparam int CLK_DEFAULT_DIV = 5_000_000;

    // The reserved encoding is treated exactly like HALT.
    function automatic logic mode_is_halt(input mode_e m);
        return (m == HALT) || (m == RSVD);
    endfunction

endpackage

// File: rtl/clock_div_ch.sv
// ---------------------------------------------------------------------------
// clock_div_ch
// One divided-clock channel: counter, active divisor and pending (shadow)
// divisor with its valid flag.
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   i_run           effective mode is RUN
//   i_step_clr      first cycle of STEP mode: clear the counter
//   i_step_tick     qualified step_req rising edge: emit one tick
//   i_div_val       requested divisor
//   i_div_load      strobe to capture i_div_val
//   o_tick          one-cycle enable pulse
//   o_clk_div       square wave, toggles with every tick
// ---------------------------------------------------------------------------
module clock_div_ch
    import clock_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = CLK_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_run,
    input  logic             i_step_clr,
    input  logic             i_step_tick,
    input  logic [WIDTH-1:0] i_div_val,
    input  logic             i_div_load,
    output logic             o_tick,
    output logic             o_clk_div
);

    localparam logic [WIDTH-1:0] LP_DIV_RST = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_pend;
    logic             r_pend_vld;
    logic             r_tick;
    logic             r_clk_div;

    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_div_nxt;
    logic [WIDTH-1:0] w_pend_nxt;
    logic             w_pend_vld_nxt;
    logic             w_tick_nxt;
    logic             w_clk_div_nxt;
    logic             w_wrap;

    assign w_wrap = !(r_cnt < r_div);

    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_div_nxt      = r_div;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        w_tick_nxt     = 1'b0;
        w_clk_div_nxt  = r_clk_div;

        if (i_run) begin
            if (w_wrap) begin
                w_cnt_nxt     = '0;
                w_tick_nxt    = 1'b1;
                w_clk_div_nxt = ~r_clk_div;
                // A load landing on the wrap cycle stays pending until the
                // following wrap, so the shadow is only promoted without one.
                if (r_pend_vld && !i_div_load) begin
                    w_div_nxt      = r_pend;
                    w_pend_vld_nxt = 1'b0;
                end
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
            if (i_div_load) begin
                w_pend_nxt     = i_div_val;
                w_pend_vld_nxt = 1'b1;
            end
        end else begin
            // HALT / STEP: a load takes effect immediately and restarts the count.
            if (i_div_load) begin
                w_div_nxt      = i_div_val;
                w_cnt_nxt      = '0;
                w_pend_vld_nxt = 1'b0;
            end else if (i_step_clr) begin
                w_cnt_nxt = '0;
            end
            if (i_step_tick) begin
                w_tick_nxt    = 1'b1;
                w_clk_div_nxt = ~r_clk_div;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_div      <= LP_DIV_RST;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_tick     <= 1'b0;
            r_clk_div  <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_div      <= w_div_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_tick     <= w_tick_nxt;
            r_clk_div  <= w_clk_div_nxt;
        end
    end

    assign o_tick    = r_tick;
    assign o_clk_div = r_clk_div;

endmodule

// File: rtl/clock_ctrl.sv
// ---------------------------------------------------------------------------
// clock_ctrl
// Multi-channel clock divider with RUN / STEP / HALT run control.
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   mode      run control (RUN=00, STEP=01, HALT=10, 11 behaves as HALT)
//   step_req  debounced step button level
//   div_val   N_CH packed divisors, channel g at [g*WIDTH +: WIDTH]
//   div_load  per-channel strobe to latch div_val
//   tick      per-channel one-cycle enable pulse
//   clk_div   per-channel square wave, toggles on each tick
//   halted    high while mode is HALT or reserved (combinational)
// ---------------------------------------------------------------------------
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int N_CH        = 2,
    parameter int DEFAULT_DIV = CLK_DEFAULT_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic                  step_req,
    input  logic [N_CH*WIDTH-1:0] div_val,
    input  logic [N_CH-1:0]       div_load,
    output logic [N_CH-1:0]       tick,
    output logic [N_CH-1:0]       clk_div,
    output logic                  halted
);

    mode_e w_mode;
    mode_e r_mode_prev;
    logic  r_step_prev;
    logic  w_run;
    logic  w_step_entry;
    logic  w_step_tick;

    assign w_mode = mode_e'(mode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_prev <= RUN;
            r_step_prev <= 1'b0;
        end else begin
            r_mode_prev <= w_mode;
            r_step_prev <= step_req;
        end
    end

    // Mode decode. A step edge is honoured only when STEP was already the
    // mode on the previous cycle, which discards edges coincident with a
    // mode change (including entry into STEP).
    always_comb begin
        w_run        = 1'b0;
        w_step_entry = 1'b0;
        w_step_tick  = 1'b0;
        unique case (w_mode)
            RUN: w_run = 1'b1;
            STEP: begin
                w_step_entry = (r_mode_prev != STEP);
                w_step_tick  = !w_step_entry && step_req && !r_step_prev;
            end
            default: ;
        endcase
    end

    assign halted = mode_is_halt(w_mode);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clock_div_ch #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_run       (w_run),
            .i_step_clr  (w_step_entry),
            .i_step_tick (w_step_tick),
            .i_div_val   (div_val[g*WIDTH +: WIDTH]),
            .i_div_load  (div_load[g]),
            .o_tick      (tick[g]),
            .o_clk_div   (clk_div[g])
        );
    end

endmodule

// File: tb/tb_clock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_ctrl
// Directed bench for clock_ctrl (WIDTH=8, N_CH=2, DEFAULT_DIV=3). Expected
// ticks (cycle, channel, clk_div level) are queued as stimulus is applied; a
// monitor consumes them on every falling edge.
// ---------------------------------------------------------------------------
module tb_clock_ctrl;

    localparam int W  = 8;
    localparam int NC = 2;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic [1:0]      mode     = 2'b00;
    logic            step_req = 1'b0;
    logic [NC*W-1:0] div_val  = '0;
    logic [NC-1:0]   div_load = '0;
    logic [NC-1:0]   tick;
    logic [NC-1:0]   clk_div;
    logic            halted;

    clock_ctrl #(
        .WIDTH       (W),
        .N_CH        (NC),
        .DEFAULT_DIV (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .step_req (step_req),
        .div_val  (div_val),
        .div_load (div_load),
        .tick     (tick),
        .clk_div  (clk_div),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   ch;
        int   cyc;
        logic lvl;
    } exp_t;

    exp_t        sb[$];
    logic [NC-1:0] exp_clk = '0;
    int          n_vec = 0;
    int          n_err = 0;

    // Advance to just after the rising edge that makes cyc == c.
    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Queue one expected tick, kept sorted by cycle then channel.
    task automatic exp_tick(input int ch, input int c);
        exp_t e;
        int   i;
        exp_clk[ch] = ~exp_clk[ch];
        e.ch  = ch;
        e.cyc = c;
        e.lvl = exp_clk[ch];
        i = 0;
        while (i < sb.size() && (sb[i].cyc < c || (sb[i].cyc == c && sb[i].ch < ch)))
            i++;
        sb.insert(i, e);
    endtask

    task automatic exp_series(input int ch, input int first, input int period, input int n);
        for (int k = 0; k < n; k++) exp_tick(ch, first + k * period);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missed_tick ch%0d: got no tick, expected tick at cycle %0d", e.ch, e.cyc);
            end
            for (int ch = 0; ch < NC; ch++) begin
                if (tick[ch]) begin
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_tick ch%0d: got tick at cycle %0d, expected none", ch, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (e.ch != ch || e.cyc != cyc || e.lvl != clk_div[ch]) begin
                            n_err++;
                            $display("FAIL tick ch%0d: got cycle %0d clk_div %0b, expected ch%0d cycle %0d clk_div %0b",
                                     ch, cyc, clk_div[ch], e.ch, e.cyc, e.lvl);
                        end
                    end
                end
            end
        end
    endtask

    int R, H, S, T, P, Q, R2;

    initial begin
        fork
            monitor();
            begin
                #50000;
                $display("FAIL timeout: simulation did not complete in time");
                $fatal(1, "timeout");
            end
        join_none

        // Reset state and combinational halted while in reset.
        @(posedge clk);
        #1;
        chk("reset_tick", int'(tick), 0);
        chk("reset_clk_div", int'(clk_div), 0);
        chk("reset_halted_run", int'(halted), 0);
        mode = 2'b11;
        #1 chk("reset_halted_rsvd", int'(halted), 1);
        mode = 2'b10;
        #1 chk("reset_halted_halt", int'(halted), 1);
        mode = 2'b00;
        #1;
        go(cyc + 2);

        // RUN with reset divisor 3: first tick 4 cycles after release, period 4.
        R = cyc;
        rst_n = 1'b1;
        exp_series(0, R + 4, 4, 4);
        exp_series(1, R + 4, 4, 4);
        go(R + 17);
        mode = 2'b10;
        go(R + 18);
        chk("halt_flag", int'(halted), 1);
        chk("clk_div_after_4", int'(clk_div), 0);

        // Divisor 0 on both, then ch0 reloaded to 2 on a wrap cycle.
        H = cyc;
        div_val  = {8'd0, 8'd0};
        div_load = 2'b11;
        go(H + 1);
        div_load = 2'b00;
        mode     = 2'b00;
        S = cyc;
        exp_series(0, S + 1, 1, 5);
        exp_series(0, S + 8, 3, 3);
        exp_series(1, S + 1, 1, 14);
        go(S + 3);
        div_val[7:0] = 8'd2;
        div_load     = 2'b01;
        go(S + 4);
        div_load = 2'b00;
        go(S + 14);
        mode = 2'b10;

        // ch0 div 4 / ch1 div 3, halt at counter 2 for 10 cycles, resume.
        go(S + 15);
        T = cyc;
        div_val  = {8'd3, 8'd4};
        div_load = 2'b11;
        go(T + 1);
        div_load = 2'b00;
        mode     = 2'b00;
        #1 chk("run_halted_low", int'(halted), 0);
        go(T + 3);
        mode = 2'b10;
        go(T + 5);
        step_req = 1'b1;
        go(T + 6);
        step_req = 1'b0;
        go(T + 13);
        mode = 2'b00;
        exp_series(0, T + 16, 5, 2);
        exp_series(1, T + 15, 4, 3);

        // Enter STEP with step_req rising on the same cycle: edge discarded.
        go(T + 23);
        mode     = 2'b01;
        step_req = 1'b1;
        go(T + 24);
        P = cyc;
        step_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            go(P + 1 + 6 * k);
            step_req = 1'b1;
            exp_tick(0, P + 2 + 6 * k);
            exp_tick(1, P + 2 + 6 * k);
            go(P + 2 + 6 * k);
            step_req = 1'b0;
        end
        go(P + 15);
        chk("step_clk_div_inverted", int'(clk_div), 1);
        go(P + 20);
        step_req = 1'b1;
        exp_tick(0, P + 21);
        exp_tick(1, P + 21);
        go(P + 40);
        step_req = 1'b0;

        // Divisor 1 on both; ch0 loads 7 on a wrap cycle.
        go(P + 41);
        Q = cyc;
        div_val  = {8'd1, 8'd1};
        div_load = 2'b11;
        go(Q + 1);
        div_load = 2'b00;
        mode     = 2'b00;
        exp_series(0, Q + 3, 2, 3);
        exp_series(0, Q + 15, 8, 2);
        exp_series(1, Q + 3, 2, 11);
        go(Q + 4);
        div_val[7:0] = 8'd7;
        div_load     = 2'b01;
        go(Q + 5);
        div_load = 2'b00;

        // Asynchronous reset between clock edges.
        go(Q + 25);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tick", int'(tick), 0);
        chk("async_rst_clk_div", int'(clk_div), 0);
        mode = 2'b11;
        #1 chk("async_rst_halted_rsvd", int'(halted), 1);
        mode = 2'b00;
        #1 chk("async_rst_halted_run", int'(halted), 0);
        go(cyc + 3);
        R2 = cyc;
        rst_n   = 1'b1;
        exp_clk = '0;
        exp_series(0, R2 + 4, 4, 2);
        exp_series(1, R2 + 4, 4, 2);
        go(R2 + 9);
        mode = 2'b11;
        #1 chk("rsvd_halted", int'(halted), 1);
        go(R2 + 22);
        go(cyc + 1);
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
